// File: rtl/dm_pkg.sv
// Debug-module transport types shared by the DMI access path: request/response
// structs, DTM op codes and the sticky dmistat encoding.
package dm;

  localparam int unsigned DmiAbits = 7;   // address bits carried in dmi_req_t
  localparam int unsigned DmiDataW = 32;  // data field of the scan word
  localparam int unsigned DmiOpW   = 2;   // op/status field of the scan word

  typedef enum logic [1:0] {
    DtmNop   = 2'h0,
    DtmRead  = 2'h1,
    DtmWrite = 2'h2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DmiNoError  = 2'h0,
    DmiOpFailed = 2'h2,
    DmiBusy     = 2'h3
  } dmi_error_e;

  typedef struct packed {
    logic [DmiAbits-1:0] addr;
    dtm_op_e             op;
    logic [DmiDataW-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DmiDataW-1:0] data;
    logic [1:0]          resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_jtag_access.sv
// JTAG-side DMI access controller (TCK domain). Converts an Update-DR of the DMI
// scan register into one request towards the DMI CDC, waits for the response,
// and maintains the sticky dmistat and the Capture-DR word.
// Optional feature: define DMI_ACCESS_TIMEOUT_EN to abort an access whose
// response has not arrived after TimeoutCycles TCK cycles.
module dmi_jtag_access
  import dm::*;
#(
  parameter int unsigned AbitsW        = 7,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic                tck_i,
  input  logic                trst_ni,
  input  logic                dmi_capture_i,
  input  logic                dmi_update_i,
  input  logic [AbitsW+33:0]  dmi_scan_i,
  output logic [AbitsW+33:0]  dmi_capture_o,
  input  logic                dmireset_i,
  input  logic                dmihardreset_i,
  output logic [1:0]          dmistat_o,
  output dmi_req_t            dmi_req_o,
  output logic                dmi_req_valid_o,
  input  logic                dmi_req_ready_i,
  input  dmi_resp_t           dmi_resp_i,
  input  logic                dmi_resp_valid_i,
  output logic                dmi_resp_ready_o
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWaitRead,
    StWrite,
    StWaitWrite
  } state_e;

  state_e              state_q, state_d;
  logic [AbitsW-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  dmi_error_e          dmistat_q, dmistat_d;
  logic                discard_q, discard_d;
  logic [AbitsW+33:0]  capture_q, capture_d;
  logic                set_failed, set_busy;

  // Scan word fields: {addr, data[31:0], op[1:0]}.
  logic [AbitsW-1:0] scan_addr;
  logic [31:0]       scan_data;
  logic [1:0]        scan_op;
  assign scan_addr = dmi_scan_i[AbitsW+33:34];
  assign scan_data = dmi_scan_i[33:2];
  assign scan_op   = dmi_scan_i[1:0];

`ifdef DMI_ACCESS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Next-state, datapath updates and request outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    dmistat_d       = dmistat_q;
    discard_d       = discard_q;
    capture_d       = capture_q;
    set_failed      = 1'b0;
    set_busy        = 1'b0;
    dmi_req_valid_o = 1'b0;
    dmi_req_o       = '0;
`ifdef DMI_ACCESS_TIMEOUT_EN
    cnt_d           = cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (dmi_update_i) begin
          if (discard_q) begin
            // A stale response is still owed to us; a new access must wait.
            set_busy = 1'b1;
          end else if (dmistat_q == DmiNoError) begin
            if (scan_op == DtmRead) begin
              addr_d  = scan_addr;
              state_d = StRead;
            end else if (scan_op == DtmWrite) begin
              addr_d  = scan_addr;
              data_d  = scan_data;
              state_d = StWrite;
            end
          end
        end
      end
      StRead: begin
        dmi_req_valid_o = 1'b1;
        dmi_req_o       = '{addr: addr_q, op: DtmRead, data: data_q};
        if (dmi_req_ready_i) state_d = StWaitRead;
      end
      StWrite: begin
        dmi_req_valid_o = 1'b1;
        dmi_req_o       = '{addr: addr_q, op: DtmWrite, data: data_q};
        if (dmi_req_ready_i) state_d = StWaitWrite;
      end
      StWaitRead: begin
        if (dmi_resp_valid_i) begin
          state_d = StIdle;
          if (dmi_resp_i.resp == 2'b00) data_d = dmi_resp_i.data;
          else                          set_failed = 1'b1;
        end
      end
      StWaitWrite: begin
        if (dmi_resp_valid_i) begin
          state_d = StIdle;
          if (dmi_resp_i.resp != 2'b00) set_failed = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Any scan activity while an access is in flight is flagged busy.
    if (state_q != StIdle && (dmi_update_i || dmi_capture_i)) set_busy = 1'b1;

    if (dmi_capture_i) begin
      capture_d = {addr_q, data_q, (state_q == StIdle) ? dmistat_q : DmiBusy};
    end

    // The stale response after an abort is swallowed exactly once.
    if (discard_q && dmi_resp_valid_i) discard_d = 1'b0;

`ifdef DMI_ACCESS_TIMEOUT_EN
    if (state_q == StRead || state_q == StWrite) begin
      cnt_d = '0;
    end else if ((state_q == StWaitRead || state_q == StWaitWrite) && !dmi_resp_valid_i) begin
      if (cnt_q == TimeoutLast) begin
        state_d    = StIdle;
        set_failed = 1'b1;
        discard_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif

    // Sticky status: busy is never downgraded, and a clear wins over any set.
    if (set_failed && dmistat_q != DmiBusy) dmistat_d = DmiOpFailed;
    if (set_busy)                           dmistat_d = DmiBusy;
    if (dmireset_i)                         dmistat_d = DmiNoError;

    // Hard reset aborts everything; an already-accepted request still owes a response.
    if (dmihardreset_i) begin
      state_d   = StIdle;
      dmistat_d = DmiNoError;
      addr_d    = addr_q;
      data_d    = data_q;
      if ((state_q == StWaitRead || state_q == StWaitWrite) && !dmi_resp_valid_i) begin
        discard_d = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!trst_ni) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Datapath and status registers.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    // NOTE: these are plain flops, not a memory, so every one of them is reset.
    if (!trst_ni) begin
      addr_q    <= '0;
      data_q    <= '0;
      dmistat_q <= DmiNoError;
      discard_q <= 1'b0;
      capture_q <= '0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      dmistat_q <= dmistat_d;
      discard_q <= discard_d;
      capture_q <= capture_d;
    end
  end

`ifdef DMI_ACCESS_TIMEOUT_EN
  // Wait-state cycle counter for the response timeout.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  assign dmi_capture_o    = capture_q;
  assign dmistat_o        = dmistat_q;
  assign dmi_resp_ready_o = 1'b1;

  // Parameter sanity: the request struct carries a fixed address width and the timeout must be non-zero.
  a_params: assert property (@(posedge tck_i) (AbitsW == DmiAbits) && (TimeoutCycles > 0));

  // A pending request must not change until it is accepted or aborted.
  a_req_stable: assert property (@(posedge tck_i) disable iff (!trst_ni)
    (dmi_req_valid_o && !dmi_req_ready_i && !dmihardreset_i) |=> (dmi_req_valid_o && $stable(dmi_req_o)));

  // A response in Idle is only legal when it is the stale one being drained.
  a_no_stray_resp: assert property (@(posedge tck_i) disable iff (!trst_ni)
    (state_q == StIdle && !discard_q) |-> !dmi_resp_valid_i);

endmodule

// File: tb/tb_dmi_jtag_access.sv
// Scoreboard bench for dmi_jtag_access: stimulus tasks push expected requests,
// capture words and dmistat values; an independent monitor compares them as the
// DUT presents them. The reference model tracks the access at transaction level.
module tb_dmi_jtag_access;
  import dm::*;

  logic        tck_i = 1'b0;
  logic        trst_ni;
  logic        dmi_capture_i, dmi_update_i;
  logic [40:0] dmi_scan_i, dmi_capture_o;
  logic        dmireset_i, dmihardreset_i;
  logic [1:0]  dmistat_o;
  dmi_req_t    dmi_req_o;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  dmi_resp_t   dmi_resp_i;
  logic        dmi_resp_valid_i, dmi_resp_ready_o;
  logic        stat_chk;

  dmi_jtag_access #(.AbitsW(7), .TimeoutCycles(8)) dut (
    .tck_i(tck_i), .trst_ni(trst_ni),
    .dmi_capture_i(dmi_capture_i), .dmi_update_i(dmi_update_i),
    .dmi_scan_i(dmi_scan_i), .dmi_capture_o(dmi_capture_o),
    .dmireset_i(dmireset_i), .dmihardreset_i(dmihardreset_i),
    .dmistat_o(dmistat_o),
    .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o)
  );

  always #5 tck_i = ~tck_i;

  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
    bit          chk_data;
  } exp_req_t;

  exp_req_t    exp_req_q[$];
  logic [40:0] exp_cap_q[$];
  logic [1:0]  exp_stat_q[$];

  // Reference model: what the debugger should observe.
  logic [6:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_stat = 2'd0;
  bit          m_discard = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck_i);
    #1;
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin : monitor
    bit cap_prev;
    exp_req_t e;
    cap_prev = 1'b0;
    forever begin
      @(negedge tck_i);
      if (!trst_ni) begin
        cap_prev = 1'b0;
        continue;
      end
      if (dmi_req_valid_o && dmi_req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: actual=0x%0h required=none", dmi_req_o);
        end else begin
          e = exp_req_q.pop_front();
          check("req_addr", 64'(dmi_req_o.addr), 64'(e.addr));
          check("req_op", 64'(dmi_req_o.op), 64'(e.op));
          if (e.chk_data) check("req_data", 64'(dmi_req_o.data), 64'(e.data));
        end
      end
      if (cap_prev) begin
        if (exp_cap_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL capture_unexpected: actual=0x%0h required=none", dmi_capture_o);
        end else begin
          check("capture_word", 64'(dmi_capture_o), 64'(exp_cap_q.pop_front()));
        end
      end
      cap_prev = dmi_capture_i;
      if (stat_chk && exp_stat_q.size() != 0) check("dmistat", 64'(dmistat_o), 64'(exp_stat_q.pop_front()));
    end
  end

  task automatic do_update(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    dmi_scan_i   = {a, d, op};
    dmi_update_i = 1'b1;
    tick();
    dmi_update_i = 1'b0;
  endtask

  task automatic stat_check();
    exp_stat_q.push_back(m_stat);
    stat_chk = 1'b1;
    tick();
    stat_chk = 1'b0;
  endtask

  // Idle capture: expected word comes from the model, followed by a dmistat check.
  task automatic capture_check();
    exp_cap_q.push_back({m_addr, m_data, m_stat});
    dmi_capture_i = 1'b1;
    tick();
    dmi_capture_i = 1'b0;
    tick();
    stat_check();
  endtask

  task automatic do_dmireset();
    dmireset_i = 1'b1;
    tick();
    dmireset_i = 1'b0;
    m_stat = 2'd0;
  endtask

  task automatic do_hardreset();
    dmihardreset_i = 1'b1;
    tick();
    dmihardreset_i = 1'b0;
  endtask

  // CDC write side: wait (bounded) for a request, then accept after rdy cycles.
  task automatic serve_handshake(input int rdy);
    int n = 0;
    while (!dmi_req_valid_o && n < 20) begin
      tick();
      n++;
    end
    check("req_valid_seen", 64'(dmi_req_valid_o), 64'd1);
    repeat (rdy) tick();
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
  endtask

  task automatic send_resp(input logic [31:0] d, input logic [1:0] r);
    dmi_resp_i       = '{data: d, resp: r};
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
  endtask

  // One DMI access; poke=1 adds a second update mid-flight, poke=2 a capture mid-flight.
  task automatic access(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                        input int rdy, input int rsp, input logic [1:0] rerr,
                        input logic [31:0] rdata, input int poke);
    bit issues;
    issues = (m_stat == 2'd0) && !m_discard && (op == 2'd1 || op == 2'd2);
    do_update(op, a, d);
    if (!issues) begin
      if (m_discard) m_stat = 2'd3;
      repeat (3) tick();
      return;
    end
    m_addr = a;
    if (op == 2'd2) m_data = d;
    exp_req_q.push_back('{addr: a, op: op, data: d, chk_data: (op == 2'd2)});
    serve_handshake(rdy);
    if (poke == 1) begin
      do_update(2'($urandom_range(0, 3)), 7'($urandom), $urandom);
      m_stat = 2'd3;
    end else if (poke == 2) begin
      exp_cap_q.push_back({m_addr, m_data, 2'd3});
      dmi_capture_i = 1'b1;
      tick();
      dmi_capture_i = 1'b0;
      m_stat = 2'd3;
    end
    repeat (rsp) tick();
    send_resp(rdata, rerr);
    if (rerr != 2'd0) begin
      if (m_stat != 2'd3) m_stat = 2'd2;
    end else if (op == 2'd1) begin
      m_data = rdata;
    end
  endtask

  // Hard reset after the read was accepted: the late response must be dropped.
  task automatic hardreset_wait(input logic [6:0] a, input int rdy, input bit poke_upd);
    if (m_stat != 2'd0) do_dmireset();
    do_update(2'd1, a, $urandom);
    m_addr = a;
    exp_req_q.push_back('{addr: a, op: 2'd1, data: 32'd0, chk_data: 1'b0});
    serve_handshake(rdy);
    tick();
    do_hardreset();
    m_stat    = 2'd0;
    m_discard = 1'b1;
    stat_check();
    if (poke_upd) begin
      do_update(2'd2, 7'($urandom), $urandom);
      m_stat = 2'd3;
    end
    send_resp($urandom, 2'd0);
    m_discard = 1'b0;
    tick();
    capture_check();
  endtask

  // Hard reset before the request was accepted: the request is withdrawn.
  task automatic hardreset_pending(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    if (m_stat != 2'd0) do_dmireset();
    do_update(op, a, d);
    m_addr = a;
    if (op == 2'd2) m_data = d;
    repeat (2) tick();
    do_hardreset();
    m_stat = 2'd0;
    tick();
    capture_check();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    logic [1:0] rerr;
    trst_ni          = 1'b0;
    dmi_capture_i    = 1'b0;
    dmi_update_i     = 1'b0;
    dmi_scan_i       = '0;
    dmireset_i       = 1'b0;
    dmihardreset_i   = 1'b0;
    dmi_req_ready_i  = 1'b0;
    dmi_resp_i       = '0;
    dmi_resp_valid_i = 1'b0;
    stat_chk         = 1'b0;

    #12;
    check("rst_dmistat", 64'(dmistat_o), 64'd0);
    check("rst_capture", 64'(dmi_capture_o), 64'd0);
    check("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
    check("rst_req", 64'(dmi_req_o), 64'd0);
    check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
    tick();
    trst_ni = 1'b1;
    tick();

    // Write with a 3-cycle ready stall, clean response.
    access(2'd2, 7'h10, 32'hDEADBEEF, 3, 1, 2'd0, 32'h0, 0);
    capture_check();
    // Read returning data.
    access(2'd1, 7'h11, 32'h0, 0, 2, 2'd0, 32'h12345678, 0);
    capture_check();
    // Busy: second update in flight, later update ignored until dmireset.
    access(2'd1, 7'h20, 32'h0, 1, 2, 2'd0, 32'hCAFE0001, 1);
    capture_check();
    access(2'd2, 7'h21, 32'h11111111, 0, 0, 2'd0, 32'h0, 0);
    capture_check();
    do_dmireset();
    access(2'd2, 7'h22, 32'h22222222, 0, 0, 2'd0, 32'h0, 0);
    capture_check();
    // Capture during an access reports busy.
    access(2'd2, 7'h23, 32'h33333333, 2, 1, 2'd0, 32'h0, 2);
    capture_check();
    do_dmireset();
    // Failed read: data unchanged, following write issues nothing.
    access(2'd1, 7'h30, 32'h0, 0, 1, 2'd2, 32'hBADBAD00, 0);
    capture_check();
    access(2'd2, 7'h31, 32'h44444444, 0, 0, 2'd0, 32'h0, 0);
    capture_check();
    do_dmireset();
    // Reserved op is a no-op.
    access(2'd3, 7'h32, 32'h55555555, 0, 0, 2'd0, 32'h0, 0);
    capture_check();
    // Hard reset in WaitRead, stale response dropped, then a normal read.
    hardreset_wait(7'h40, 1, 1'b0);
    access(2'd1, 7'h41, 32'h0, 0, 0, 2'd0, 32'h0BADF00D, 0);
    capture_check();
    hardreset_wait(7'h42, 0, 1'b1);
    do_dmireset();
    hardreset_pending(2'd2, 7'h43, 32'h66666666);

`ifdef DMI_ACCESS_TIMEOUT_EN
    // No response: access aborts after the timeout, the late response is dropped.
    do_update(2'd1, 7'h50, 32'h0);
    m_addr = 7'h50;
    exp_req_q.push_back('{addr: 7'h50, op: 2'd1, data: 32'd0, chk_data: 1'b0});
    serve_handshake(0);
    repeat (12) tick();
    m_stat    = 2'd2;
    m_discard = 1'b1;
    capture_check();
    send_resp(32'h77777777, 2'd0);
    m_discard = 1'b0;
    capture_check();
    do_dmireset();
`else
    // No response: access stays in flight indefinitely.
    do_update(2'd1, 7'h50, 32'h0);
    m_addr = 7'h50;
    exp_req_q.push_back('{addr: 7'h50, op: 2'd1, data: 32'd0, chk_data: 1'b0});
    serve_handshake(0);
    repeat (100) tick();
    exp_cap_q.push_back({m_addr, m_data, 2'd3});
    dmi_capture_i = 1'b1;
    tick();
    dmi_capture_i = 1'b0;
    m_stat = 2'd3;
    tick();
    stat_check();
    do_hardreset();
    m_stat    = 2'd0;
    m_discard = 1'b1;
    send_resp(32'h77777777, 2'd0);
    m_discard = 1'b0;
    capture_check();
`endif

    // Randomized mix of accesses, errors, busy pokes and hard resets.
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (m_stat != 2'd0 && $urandom_range(0, 1) == 1) do_dmireset();
      if (kind <= 6) begin
        rerr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        access(2'($urandom_range(0, 3)), 7'($urandom), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), rerr, $urandom,
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
        capture_check();
      end else if (kind <= 8) begin
        hardreset_wait(7'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end else begin
        hardreset_pending(2'($urandom_range(1, 2)), 7'($urandom), $urandom);
      end
    end

    repeat (4) tick();
    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
    check("cap_queue_drained", 64'(exp_cap_q.size()), 64'd0);
    check("stat_queue_drained", 64'(exp_stat_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
